baud_gen: RTL and testbench
===========================

// Module: baud_gen
// PURPOSE
//  - Programmable baud-rate tick generator for the UART: divides clk by run-time value dvsr.
//  - Emits a single-cycle strobe (tick) every dvsr clocks; this is the oversampling tick for uart_rx/uart_tx.
//  - Sizing: dvsr = f_clk / (16 * baud), e.g. 100 MHz, 9600 baud -> dvsr = 651.
// PARAMETERS
//  - DVSR_W  11  width of dvsr and of the internal counter
//  - OVS     16  oversampling ratio; used only when BAUD_GEN_BIT_TICK_EN is defined
// PORTS
//  - clk       in   1        single clock, rising edge
//  - reset     in   1        asynchronous, active-low (asserted at 0); release is synchronous to clk upstream
//  - dvsr      in   DVSR_W   divisor, unsigned, sampled every cycle
//  - tick      out  1        registered one-cycle strobe, one per dvsr clocks
//  - bit_tick  out  1        (BAUD_GEN_BIT_TICK_EN only) registered strobe, one per OVS ticks
// BEHAVIOUR
//  - Reset (reset==0): cnt=0, tick=0 (and bit_cnt=0, bit_tick=0) immediately, independent of clk.
//  - Counter cnt, DVSR_W bits, counts 0..dvsr-1.
//  - Each rising edge when dvsr>=2:
//      cnt >= dvsr-1 : cnt<=0, tick<=1
//      otherwise     : cnt<=cnt+1, tick<=0
//  - dvsr==0 or dvsr==1: tick<=1 every cycle (continuous high), cnt held at 0.
//  - tick is a flop output, no combinational path from dvsr.
//  - Latency: first tick is high in the cycle after the dvsr-th rising edge following reset release.
//    Spacing: exactly dvsr cycles between rising edges of tick; high for exactly 1 cycle (dvsr>=2).
//  - dvsr change mid-count:
//      new dvsr-1 > cnt : counting continues to the new terminal value
//      new dvsr-1 <= cnt: wraps on the next edge (the >= compare); no counter run-away through 2^DVSR_W
//  - Compare arithmetic: dvsr-1 computed in DVSR_W bits, guarded by the dvsr<=1 branch, so never underflows.
//  - Max dvsr = 2^DVSR_W-1; cnt never exceeds dvsr-1, so no wrap-around of cnt.
//  - Reset asserted mid-count: outputs drop to 0 at once.
//    After release, counting restarts from 0 with full first-tick latency.
// CONFIGURATION
//  - Macro BAUD_GEN_BIT_TICK_EN.
//  - Defined:
//      second counter bit_cnt (width $clog2(OVS)) advances on each cycle where the tick flop updates to 1;
//      when bit_cnt wraps OVS-1 -> 0, bit_tick<=1 in the same cycle tick<=1, else bit_tick<=0;
//      bit_tick is coincident with every OVS-th tick; first bit_tick is on the OVS-th tick after reset.
//  - Undefined: bit_tick port and bit_cnt absent; tick behaviour identical.
// STRUCTURE
//  - Package baud_gen_pkg:
//      localparam DVSR_W_DEF=11, OVS_DEF=16;
//      typedef logic [DVSR_W_DEF-1:0] dvsr_t;
//      function calc_dvsr(clk_hz, baud, ovs) returning rounded clk_hz/(ovs*baud).
//  - Sub-module baud_mod_cnt: generic modulo-N counter with enable, terminal-count strobe, async active-low reset.
//      Instantiated once for tick (N=dvsr, en=1).
//      Instantiated again under BAUD_GEN_BIT_TICK_EN (N=OVS, en=tick-next).
// TESTING
//  1. dvsr=651, reset low 10 ns then high, 100 MHz clk:
//     first tick one cycle after the 651st edge; ticks every 6510 ns; each tick 10 ns wide; ~76 ticks in 500 us.
//  2. dvsr=4: tick pattern 0,0,0,1 repeating, period 4 cycles.
//  3. dvsr=0 and dvsr=1: tick constantly 1 after the first edge; dvsr=2 -> alternating 0,1.
//  4. dvsr=100 with cnt=50, switch dvsr to 20: tick on next edge, then every 20 cycles.
//     Switch 20->200 at cnt=5: next tick 195 cycles later.
//  5. reset low mid-count (cnt=300, dvsr=651): tick/cnt 0 immediately without clk edge;
//     after release first tick again 651 edges later.
//  6. BAUD_GEN_BIT_TICK_EN, dvsr=4, OVS=16: bit_tick every 64 cycles, coincident with every 16th tick.

Source files
------------

// File: rtl/baud_gen_pkg.sv
// Shared sizing constants, divisor type and divisor calculator for baud_gen.
package baud_gen_pkg;

    localparam int unsigned DVSR_W_DEF = 11;
    localparam int unsigned OVS_DEF    = 16;

    typedef logic [DVSR_W_DEF-1:0] dvsr_t;

    // Rounded clk_hz / (ovs * baud), saturated to the divisor range; 0 on a zero denominator.
    function automatic dvsr_t calc_dvsr(input longint unsigned clk_hz,
                                        input longint unsigned baud,
                                        input longint unsigned ovs);
        longint unsigned den;
        longint unsigned q;
        longint unsigned q_max;
        den   = ovs * baud;
        q_max = (64'd1 << DVSR_W_DEF) - 64'd1;
        if (den == 64'd0) begin
            q = 64'd0;
        end else begin
            q = (clk_hz + (den >> 1)) / den;
        end
        if (q > q_max) begin
            q = q_max;
        end
        return DVSR_W_DEF'(q);
    endfunction

endpackage

// File: rtl/baud_mod_cnt.sv
// Generic modulo counter: counts 0..last while en is high and raises the
// combinational terminal-count strobe tc_c on the wrap cycle.
//   clk, reset  : clock, asynchronous active-low reset
//   en          : advance enable
//   single      : modulus 0/1 -> counter parked at 0, tc_c every enabled cycle
//   last        : terminal value (modulus - 1)
//   tc_c        : high in the cycle the counter wraps to 0
module baud_mod_cnt #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         single,
    input  logic [W-1:0] last,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count; >= so a modulus lowered below the current count wraps at once.
    always_comb begin
        cnt_d = cnt_q;
        tc_c  = 1'b0;
        if (en) begin
            if (single || (cnt_q >= last)) begin
                cnt_d = '0;
                tc_c  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/baud_gen.sv
// Programmable baud tick generator: one-cycle tick every dvsr clocks
// (continuous high for dvsr 0/1).
// Optional feature macro BAUD_GEN_BIT_TICK_EN adds bit_tick, one strobe per
// OVS ticks, coincident with the OVS-th tick.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   dvsr     : run-time divisor, sampled every cycle
//   tick     : registered oversampling strobe
//   bit_tick : registered bit strobe (BAUD_GEN_BIT_TICK_EN only)
module baud_gen
    import baud_gen_pkg::*;
#(
    parameter int unsigned DVSR_W = DVSR_W_DEF
`ifdef BAUD_GEN_BIT_TICK_EN
    ,
    parameter int unsigned OVS    = OVS_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
`ifdef BAUD_GEN_BIT_TICK_EN
    output logic              bit_tick,
`endif
    output logic              tick
);

    logic              single_c;
    logic [DVSR_W-1:0] last_c;
    logic              tick_d;
    logic              tick_q;

    // Terminal value dvsr-1; the dvsr<=1 guard keeps the subtraction from underflowing.
    always_comb begin
        single_c = (dvsr <= DVSR_W'(1));
        last_c   = single_c ? '0 : (dvsr - DVSR_W'(1));
    end

    baud_mod_cnt #(
        .W (DVSR_W)
    ) u_tick_cnt (
        .clk    (clk),
        .reset  (reset),
        .en     (1'b1),
        .single (single_c),
        .last   (last_c),
        .tc_c   (tick_d)
    );

`ifdef BAUD_GEN_BIT_TICK_EN
    localparam int unsigned BIT_W = (OVS > 2) ? $clog2(OVS) : 1;

    logic bit_tick_d;
    logic bit_tick_q;

    // Advances on the same edge that raises tick, so bit_tick lines up with it.
    baud_mod_cnt #(
        .W (BIT_W)
    ) u_bit_cnt (
        .clk    (clk),
        .reset  (reset),
        .en     (tick_d),
        .single (OVS <= 1),
        .last   (BIT_W'(OVS - 1)),
        .tc_c   (bit_tick_d)
    );
`endif

    // Output strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q     <= 1'b0;
`ifdef BAUD_GEN_BIT_TICK_EN
            bit_tick_q <= 1'b0;
`endif
        end else begin
            tick_q     <= tick_d;
`ifdef BAUD_GEN_BIT_TICK_EN
            bit_tick_q <= bit_tick_d;
`endif
        end
    end

    assign tick = tick_q;
`ifdef BAUD_GEN_BIT_TICK_EN
    assign bit_tick = bit_tick_q;
`endif

endmodule

// File: tb/tb_baud_gen.sv
`timescale 1ns/1ps
module tb_baud_gen;
    import baud_gen_pkg::*;

    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic        tick;
`ifdef BAUD_GEN_BIT_TICK_EN
    logic        bit_tick;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    baud_gen dut (
        .clk      (clk),
        .reset    (reset),
        .dvsr     (dvsr),
`ifdef BAUD_GEN_BIT_TICK_EN
        .bit_tick (bit_tick),
`endif
        .tick     (tick)
    );

    // Behavioural model: phase = clocks since the last tick; tick fires when
    // the phase reaches the divisor (or every clock for divisors 0/1).
    int m_phase;
    bit m_tick;
    int m_ticks;
    bit m_bit;

    function automatic bit fires(input int phase, input int d);
        return (d <= 1) || (phase + 1 >= d);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_tick  <= 1'b0;
            m_ticks <= 0;
            m_bit   <= 1'b0;
        end else begin
            m_tick  <= fires(m_phase, int'(dvsr));
            m_phase <= fires(m_phase, int'(dvsr)) ? 0 : m_phase + 1;
            if (fires(m_phase, int'(dvsr))) begin
                m_ticks <= m_ticks + 1;
                m_bit   <= ((m_ticks + 1) % OVS) == 0;
            end else begin
                m_bit   <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("tick_vs_model", 64'(tick), 64'(m_tick));
`ifdef BAUD_GEN_BIT_TICK_EN
        check("bit_tick_vs_model", 64'(bit_tick), 64'(m_bit));
`endif
    end

    // Clock edges until tick is seen high; -1 on timeout.
    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < max);
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic edges(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reset pulse away from the edges, released on a falling edge.
    task automatic restart(input logic [10:0] d);
        @(posedge clk);
        #2;
        reset = 1'b0;
        dvsr  = d;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        reset = 1'b0;
        dvsr  = 11'd4;
        #3;
        check("reset_tick_no_clk", 64'(tick), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_tick", 64'(tick), 64'd0);
        check("calc_dvsr_9600", 64'(calc_dvsr(100_000_000, 9600, 16)), 64'd651);
        check("calc_dvsr_115200", 64'(calc_dvsr(100_000_000, 115200, 16)), 64'd54);

        // dvsr=4: latency and period 4
        reset = 1'b1;
        wait_tick(100, n); check("d4_first", 64'(n), 64'd4);
        for (int i = 0; i < 3; i++) begin
            wait_tick(100, n); check("d4_period", 64'(n), 64'd4);
        end

        // dvsr=651
        restart(11'd651);
        wait_tick(1000, n); check("d651_first", 64'(n), 64'd651);
        @(posedge clk); @(negedge clk);
        check("d651_width", 64'(tick), 64'd0);
        wait_tick(1000, n); check("d651_period", 64'(n), 64'd650);
        wait_tick(1000, n); check("d651_period2", 64'(n), 64'd651);
        restart(11'd651);
        cnt = 0;
        for (int i = 0; i < 50000; i++) begin
            @(posedge clk); @(negedge clk);
            if (tick === 1'b1) cnt++;
        end
        check("d651_count_500us", 64'(cnt), 64'd76);

        // dvsr=0/1 continuous, dvsr=2 alternating
        for (int d = 0; d < 2; d++) begin
            restart(11'(d));
            wait_tick(10, n); check("d01_first", 64'(n), 64'd1);
            for (int i = 0; i < 8; i++) begin
                edges(1); check("d01_high", 64'(tick), 64'd1);
            end
        end
        restart(11'd2);
        wait_tick(10, n); check("d2_first", 64'(n), 64'd2);
        for (int i = 0; i < 6; i++) begin
            edges(1); check("d2_alt", 64'(tick), 64'(i % 2));
        end

        // async reset while tick is high
        restart(11'd1);
        edges(3);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_tick", 64'(tick), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // divisor change mid-count
        restart(11'd100);
        edges(50);
        check("d100_mid", 64'(tick), 64'd0);
        dvsr = 11'd20;
        wait_tick(10, n); check("shrink_wrap", 64'(n), 64'd1);
        wait_tick(100, n); check("shrink_period", 64'(n), 64'd20);
        edges(5);
        dvsr = 11'd200;
        wait_tick(400, n); check("grow_next", 64'(n), 64'd195);

        // reset mid-count at cnt=300
        restart(11'd651);
        edges(300);
        #2;
        reset = 1'b0;
        #1;
        check("midcount_reset_tick", 64'(tick), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_tick(1000, n); check("midcount_relatency", 64'(n), 64'd651);

`ifdef BAUD_GEN_BIT_TICK_EN
        restart(11'd4);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge clk); @(negedge clk); n++;
            end while (bit_tick !== 1'b1 && n < 200);
            check("bit_tick_period", 64'(n), 64'd64);
            check("bit_tick_with_tick", 64'(tick), 64'd1);
        end
`endif

        // randomized divisor changes and reset pulses against the model
        restart(11'($urandom_range(0, 40)));
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 9) == 0) dvsr = 11'($urandom_range(0, 2047));
                else dvsr = 11'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                check("rand_async_reset", 64'(tick), 64'd0);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
